// File: rtl/boot_rom_mp_ctrl_if.sv
// boot_rom_mp_ctrl_if: TCDM-style requester bundle shared by all boot ROM ports
interface boot_rom_mp_ctrl_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                 req;
  logic [NUM_PORTS-1:0]                 wen;
  logic [NUM_PORTS-1:0]                 gnt;
  logic [NUM_PORTS-1:0]                 r_valid;
  logic [NUM_PORTS-1:0]                 r_opc;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] add;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rdata;
  modport master (output req, add, wen, input gnt, r_valid, r_rdata, r_opc);
  modport slave  (input req, add, wen, output gnt, r_valid, r_rdata, r_opc);
endinterface

// File: rtl/boot_rom_mp_ctrl.sv
// boot_rom_mp_ctrl: round-robin multi-port front end for a single-port boot ROM macro
// Define BOOT_ROM_PATCH_EN to build the post-tape-out word patch table.
module boot_rom_mp_ctrl #(
  parameter int                    NUM_PORTS      = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ROM_ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1A00_0000,
  parameter int                    OUT_REG        = 1,
  parameter int                    NUM_PATCH      = 4,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1,
  localparam int IW = NUM_PATCH > 1 ? $clog2(NUM_PATCH) : 1,
  localparam int WW = ROM_ADDR_WIDTH - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  boot_rom_mp_ctrl_if.slave     bus,
  output logic                  rom_cen_o,
  output logic [WW-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  input  logic                  patch_we_i,
  input  logic [IW-1:0]         patch_idx_i,
  input  logic                  patch_en_i,
  input  logic [WW-1:0]         patch_addr_i,
  input  logic [DATA_WIDTH-1:0] patch_data_i,
  input  logic                  patch_lock_i
);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADA_CCE5);
  logic [PW-1:0]         ptr, sel, port1, porto;
  logic                  any, in_range, rd_ok, hit, v1, err1, hit1, vo, erro;
  logic [ADDR_WIDTH-1:0] addr, off;
  logic [WW-1:0]         word, addr_q;
  logic [DATA_WIDTH-1:0] hit_data, pdata1, data1, datao;
  logic                  unused_lsb;
  // Scan downwards so the first requester at or after ptr ends up selected.
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (bus.req[(int'(ptr) + i) % NUM_PORTS]) begin
        any = ~rst_i;
        sel = PW'((int'(ptr) + i) % NUM_PORTS);
      end
  end
  assign bus.gnt    = any ? NUM_PORTS'(1) << sel : '0;
  assign addr       = bus.add[sel];
  assign off        = addr - BASE_ADDR;
  assign in_range   = addr >= BASE_ADDR && off[ADDR_WIDTH-1:ROM_ADDR_WIDTH] == '0;
  assign word       = off[ROM_ADDR_WIDTH-1:2];
  assign unused_lsb = ^off[1:0];
  assign rd_ok      = any && bus.wen[sel] && in_range;
  assign rom_cen_o  = ~rd_ok;
  assign rom_addr_o = rd_ok ? word : addr_q;
`ifdef BOOT_ROM_PATCH_EN
  logic [NUM_PATCH-1:0]                 pv;
  logic [NUM_PATCH-1:0][WW-1:0]         pa;
  logic [NUM_PATCH-1:0][DATA_WIDTH-1:0] pd;
  logic                                 lock;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pv   <= '0;
      pa   <= '0;
      pd   <= '0;
      lock <= 1'b0;
    end else begin
      lock <= lock | patch_lock_i;
      if (patch_we_i && !lock && 32'(patch_idx_i) < NUM_PATCH) begin
        pv[patch_idx_i] <= patch_en_i;
        pa[patch_idx_i] <= patch_addr_i;
        pd[patch_idx_i] <= patch_data_i;
      end
    end
  // Lookup uses the pre-write table, so a same-cycle write does not affect this read.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = NUM_PATCH - 1; i >= 0; i--)
      if (pv[i] && pa[i] == word) begin
        hit      = 1'b1;
        hit_data = pd[i];
      end
  end
`else
  logic unused_patch;
  assign unused_patch = ^{patch_we_i, patch_idx_i, patch_en_i, patch_addr_i, patch_data_i, patch_lock_i};
  assign hit          = 1'b0;
  assign hit_data     = '0;
`endif
  always_ff @(posedge clk_i)
    if (rst_i) begin
      ptr    <= '0;
      v1     <= 1'b0;
      err1   <= 1'b0;
      hit1   <= 1'b0;
      port1  <= '0;
      pdata1 <= '0;
      addr_q <= '0;
    end else begin
      if (any) ptr <= sel == PW'(NUM_PORTS - 1) ? '0 : sel + 1'b1;
      v1     <= any;
      err1   <= ~rd_ok;
      hit1   <= hit;
      port1  <= sel;
      pdata1 <= hit_data;
      addr_q <= rom_addr_o;
    end
  assign data1 = err1 ? ERR_DATA : hit1 ? pdata1 : rom_rdata_i;
  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk_i)
      if (rst_i) begin
        vo    <= 1'b0;
        erro  <= 1'b0;
        porto <= '0;
        datao <= '0;
      end else begin
        vo    <= v1;
        erro  <= err1;
        porto <= port1;
        datao <= data1;
      end
  end else begin : g_ocomb
    assign vo    = v1;
    assign erro  = err1;
    assign porto = port1;
    assign datao = data1;
  end
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_resp
    assign bus.r_valid[k] = vo && porto == PW'(k);
    assign bus.r_opc[k]   = vo && porto == PW'(k) && erro;
    assign bus.r_rdata[k] = vo && porto == PW'(k) ? datao : '0;
  end
endmodule

// File: tb/tb_boot_rom_mp_ctrl.sv
// tb_boot_rom_mp_ctrl: directed and random stimulus against a queue-based response model
module tb_boot_rom_mp_ctrl;
  localparam int NP = 2, AW = 32, DW = 32, RAW = 13, NPATCH = 4, WW = RAW - 2;
  localparam logic [31:0] BASE = 32'h1A00_0000, BAD = 32'hBADA_CCE5;
`ifdef BOOT_ROM_PATCH_EN
  localparam bit PATCH = 1'b1;
`else
  localparam bit PATCH = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  boot_rom_mp_ctrl_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic          rom_cen, patch_we, patch_en, patch_lock;
  logic [WW-1:0] rom_addr, patch_addr;
  logic [31:0]   rom_rdata, patch_data;
  logic [1:0]    patch_idx;
  boot_rom_mp_ctrl #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_ADDR_WIDTH(RAW),
    .BASE_ADDR(BASE), .OUT_REG(1), .NUM_PATCH(NPATCH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .rom_cen_o(rom_cen), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
    .patch_we_i(patch_we), .patch_idx_i(patch_idx), .patch_en_i(patch_en),
    .patch_addr_i(patch_addr), .patch_data_i(patch_data), .patch_lock_i(patch_lock)
  );
  function automatic logic [31:0] romf(input logic [WW-1:0] w);
    return 32'h5EED_0000 ^ (32'(w) * 32'h9E37_79B1);
  endfunction
  always @(posedge clk) if (!rom_cen) rom_rdata <= romf(rom_addr);
  typedef struct {int due; int port; logic err; logic [31:0] data;} resp_t;
  resp_t             q[$];
  int                ptr = 0, cyc = 0, checks = 0, errors = 0;
  logic [NP-1:0]     last_gnt = '0;
  logic [NPATCH-1:0] m_pv = '0;
  logic [WW-1:0]     m_pa[NPATCH];
  logic [31:0]       m_pd[NPATCH];
  logic              m_lock = 1'b0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask
  // One clock: check against the model, advance the model, move to the next drive point.
  task automatic step();
    logic [NP-1:0] eg, ev, eo;
    logic [31:0]   ed[NP];
    logic [31:0]   off, d;
    logic [WW-1:0] w;
    logic          rd;
    int            g;
    resp_t         r;
    #1;
    ev = '0;
    eo = '0;
    for (int k = 0; k < NP; k++) ed[k] = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      ev[r.port] = 1'b1;
      eo[r.port] = r.err;
      ed[r.port] = r.data;
    end
    chk("r_valid", 64'(bus.r_valid), 64'(ev));
    chk("r_opc", 64'(bus.r_opc), 64'(eo));
    for (int k = 0; k < NP; k++) chk($sformatf("r_rdata%0d", k), 64'(bus.r_rdata[k]), 64'(ed[k]));
    g = -1;
    if (!rst) for (int i = 0; i < NP; i++) if (g < 0 && bus.req[(ptr + i) % NP]) g = (ptr + i) % NP;
    eg = '0;
    rd = 1'b0;
    w  = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      off = bus.add[g] - BASE;
      w   = off[RAW-1:2];
      rd  = bus.wen[g] && bus.add[g] >= BASE && off < (32'd1 << RAW);
      d   = romf(w);
      if (PATCH) for (int i = NPATCH - 1; i >= 0; i--) if (m_pv[i] && m_pa[i] == w) d = m_pd[i];
      r.due  = cyc + 2;
      r.port = g;
      r.err  = !rd;
      r.data = rd ? d : BAD;
      q.push_back(r);
      ptr = (g + 1) % NP;
    end
    chk("gnt", 64'(bus.gnt), 64'(eg));
    chk("rom_cen", 64'(rom_cen), 64'(!rd));
    if (rd) chk("rom_addr", 64'(rom_addr), 64'(w));
    last_gnt = eg;
    if (rst) begin
      q.delete();
      ptr    = 0;
      m_pv   = '0;
      m_lock = 1'b0;
    end else begin
      if (PATCH && patch_we && !m_lock) begin
        m_pv[patch_idx] = patch_en;
        m_pa[patch_idx] = patch_addr;
        m_pd[patch_idx] = patch_data;
      end
      if (patch_lock) m_lock = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic rd_req(input int k, input logic [31:0] a, input logic w);
    bus.req[k] = 1'b1;
    bus.add[k] = a;
    bus.wen[k] = w;
  endtask
  task automatic idle(input int n);
    bus.req = '0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic pw(input logic [1:0] idx, input logic [WW-1:0] a, input logic [31:0] d);
    patch_we   = 1'b1;
    patch_idx  = idx;
    patch_en   = 1'b1;
    patch_addr = a;
    patch_data = d;
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      3:       return BASE + 32'h1FFC + $urandom_range(0, 7);
      4:       return BASE - $urandom_range(1, 8);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    bus.req = '1;
    bus.wen = '1;
    for (int k = 0; k < NP; k++) bus.add[k] = BASE;
    patch_we = 0; patch_idx = 0; patch_en = 0; patch_addr = '0; patch_data = '0; patch_lock = 0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    idle(3);
    rd_req(0, BASE + 32'h10, 1'b1);
    step();
    idle(3);
    rd_req(0, BASE + 32'h20, 1'b1);
    rd_req(1, BASE + 32'h44, 1'b1);
    for (int i = 0; i < 6; i++) step();
    idle(3);
    rd_req(0, BASE, 1'b0);
    step();
    rd_req(0, BASE + 32'h2000, 1'b1);
    step();
    rd_req(0, 32'h19FF_FFFC, 1'b1);
    step();
    idle(3);
    pw(2'd1, WW'(4), 32'hDEAD_BEEF);
    step();
    pw(2'd2, WW'(4), 32'h0000_0001);
    step();
    patch_we = 1'b0;
    rd_req(0, BASE + 32'h10, 1'b1);
    step();
    pw(2'd0, WW'(4), 32'hCAFE_F00D);
    step();
    patch_we = 1'b0;
    step();
    idle(3);
    patch_lock = 1'b1;
    step();
    patch_lock = 1'b0;
    pw(2'd1, WW'(4), 32'h1234_5678);
    step();
    pw(2'd0, WW'(4), 32'h1234_5678);
    step();
    patch_we = 1'b0;
    rd_req(0, BASE + 32'h10, 1'b1);
    step();
    idle(3);
    rd_req(0, BASE + 32'h10, 1'b1);
    step();
    bus.req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    rd_req(0, BASE + 32'h10, 1'b1);
    step();
    idle(3);
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NP; k++) if (!bus.req[k] || last_gnt[k]) begin
        bus.req[k] = $urandom_range(0, 3) != 0;
        bus.add[k] = rand_addr();
        bus.wen[k] = $urandom_range(0, 4) != 0;
      end
      patch_we   = $urandom_range(0, 3) == 0;
      patch_idx  = 2'($urandom);
      patch_en   = $urandom_range(0, 3) != 0;
      patch_addr = WW'($urandom_range(0, 15));
      patch_data = $urandom;
      patch_lock = $urandom_range(0, 59) == 0;
      rst        = $urandom_range(0, 49) == 0;
      step();
    end
    rst = 1'b0;
    patch_we = 1'b0;
    patch_lock = 1'b0;
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
